gcn_spmm_engine: RTL
====================

Name: gcn_spmm_engine

Overview:
- Parametrised successor to the GCN stage-1 scheduler/PE pair.
- Holds a resident block of LANES weight columns, each W_ROWS deep. Consumes a row-major sparse (COO-ordered) input stream and accumulates one dot product per lane for every row.
- Emits per-row lane results over a valid/ready output port.
- Sits between the pin-bus input deserializer and the stage-2 aggregation scheduler.

Parameters:
- DATA_W, 16, data/weight/result width, signed two's complement
- LANES, 2, weight columns processed in parallel (1..8)
- W_ROWS, 32, weight column depth = input column count
- ROW_W, 7, input row index width
- COL_W, 5, input column index width, 2^COL_W >= W_ROWS
- FRAC, 0, fixed-point fractional bits dropped from each product

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_wload  in  1  weight word valid
- i_wdata  in  DATA_W  weight word; lane-major order: lane0 rows 0..W_ROWS-1, then lane1, ...
- i_valid  in  1  sparse element valid
- i_row  in  ROW_W  element row index
- i_col  in  COL_W  element column index
- i_data  in  DATA_W  element value
- i_last  in  1  element is the final nonzero of the matrix
- o_ready  out  1  element accepted when i_valid&&o_ready
- o_valid  out  1  result word valid
- o_row  out  ROW_W  row of result word
- o_lane  out  3  lane of result word
- o_data  out  DATA_W  result word
- i_ready  in  1  downstream accepts result when o_valid&&i_ready
- o_w_ok  out  1  full weight block resident
- o_done  out  1  one-cycle pulse, matrix complete
- o_err  out  1  sticky: row order violation or column out of range

Behaviour:
- Clock is clk; reset is synchronous active-high on rst. Reset: state IDLE, all outputs 0, accumulators 0, weight-word counter 0, o_w_ok=0. Weight RAM contents are don't-care after reset.
- States: IDLE, LOAD_W, ACCUM, DRAIN.
- IDLE:
  - i_wload -> LOAD_W; that word is stored at index 0; o_w_ok cleared; o_err cleared.
  - else o_ready=o_w_ok. An accepted element opens a row (cur_row=i_row), sets acc[l]=prod(l) for all lanes, and enters ACCUM; if it also has i_last, enters DRAIN instead.
  - i_wload has priority over i_valid in the same cycle.
- LOAD_W:
  - Each i_wload stores one word and advances the counter.
  - Cycles without i_wload hold state.
  - The LANES*W_ROWS-th word sets o_w_ok=1 and returns to IDLE.
  - o_ready=0 throughout.
- ACCUM:
  - o_ready=1; i_wload is ignored.
  - Accepted element with i_row==cur_row: acc[l]+=prod(l).
  - Accepted element with i_row!=cur_row: latch acc[0..LANES-1] and cur_row into the output buffer; load acc[l]=prod(l); set cur_row=i_row; go to DRAIN.
  - Accepted element with i_row<cur_row: same as the row-change case, and o_err is set.
  - i_last on an accepted same-row element: accumulate, latch, go to DRAIN with done_pending=1.
  - i_last on an accepted row-change element: drain the old row, then drain the new row, then finish.
- prod(l) = (i_data * W[l][i_col]) evaluated to 2*DATA_W bits, bits [FRAC+DATA_W-1:FRAC] taken. Accumulation wraps modulo 2^DATA_W.
- i_col >= W_ROWS: product forced to 0; o_err set.
- DRAIN:
  - o_ready=0; o_valid=1.
  - Words are presented lane 0 first. o_row = latched row; o_lane = lane index; o_data = latched acc.
  - The lane index advances only on i_ready; o_data/o_row are stable while stalled.
  - After the last lane is accepted: if done_pending, pulse o_done and go to IDLE (o_w_ok retained); else return to ACCUM.
- Latency: first o_valid in the cycle after the accept that triggers the flush. Minimum LANES cycles per row flush at i_ready=1.
- Rows with no nonzeros emit nothing.
- rst mid-operation aborts any transfer; o_valid drops in the next cycle.

Optional Feature:
- GCN_SAT_EN defined:
  - Products are saturated to the signed DATA_W range instead of truncated.
  - Each accumulate saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Adds output o_sat (1 bit), sticky until the next IDLE->ACCUM transition, set on any clamp.
- Undefined: wrap arithmetic as above; no o_sat port.

Test Plan:
- Load 64 weights with W[0][c]=c+1 and W[1][c]=2 (LANES=2), pausing i_wload 3 cycles mid-load -> o_w_ok rises after word 64, not before; o_ready stays 0 during LOAD_W.
- Stream (r0,c0,3),(r0,c4,1),(r2,c1,-2 last), i_ready=1 -> outputs (r0,l0,8),(r0,l1,8),(r2,l0,-4),(r2,l1,-4); then o_done pulses once; no r1 output.
- Same stream with i_ready low for 5 cycles on r0 lane1 -> word held stable; o_ready stays 0; no element lost; identical results.
- Rows 5 then 3 -> r5 flushed, o_err=1; o_err stays 1 until the next weight load.
- Element 0x7FFF x weight 2 accumulated twice -> wrap result 0xFFFC without GCN_SAT_EN; 0x7FFF and o_sat=1 with it.
- Assert rst while DRAIN is stalled -> next cycle o_valid=0, o_w_ok=0, state IDLE; element accepted only after a full reload.

Source files
------------

// File: rtl/gcn_spmm_engine_if.sv
// gcn_spmm_engine_if: weight load, sparse element and result ports
// of the GCN sparse-dense multiply engine (GCN_SAT_EN adds o_sat).
interface gcn_spmm_engine_if #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 5
);
  logic              i_wload;
  logic [DATA_W-1:0] i_wdata;
  logic              i_valid;
  logic [ROW_W-1:0]  i_row;
  logic [COL_W-1:0]  i_col;
  logic [DATA_W-1:0] i_data;
  logic              i_last;
  logic              o_ready;
  logic              o_valid;
  logic [ROW_W-1:0]  o_row;
  logic [2:0]        o_lane;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic              o_w_ok;
  logic              o_done;
  logic              o_err;
`ifdef GCN_SAT_EN
  logic              o_sat;

  modport slave (
    input  i_wload, i_wdata, i_valid, i_row, i_col,
    input  i_data, i_last, i_ready,
    output o_ready, o_valid, o_row, o_lane, o_data,
    output o_w_ok, o_done, o_err, o_sat
  );

  modport master (
    output i_wload, i_wdata, i_valid, i_row, i_col,
    output i_data, i_last, i_ready,
    input  o_ready, o_valid, o_row, o_lane, o_data,
    input  o_w_ok, o_done, o_err, o_sat
  );
`else
  modport slave (
    input  i_wload, i_wdata, i_valid, i_row, i_col,
    input  i_data, i_last, i_ready,
    output o_ready, o_valid, o_row, o_lane, o_data,
    output o_w_ok, o_done, o_err
  );

  modport master (
    output i_wload, i_wdata, i_valid, i_row, i_col,
    output i_data, i_last, i_ready,
    input  o_ready, o_valid, o_row, o_lane, o_data,
    input  o_w_ok, o_done, o_err
  );
`endif
endinterface

// File: rtl/gcn_spmm_engine.sv
// gcn_spmm_engine: resident weight block x row-major COO stream,
// one dot product per lane per row. GCN_SAT_EN selects saturation.
module gcn_spmm_engine #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int W_ROWS = 32,
  parameter int ROW_W  = 7,
  parameter int COL_W  = 5,
  parameter int FRAC   = 0
) (
  input logic clk,
  input logic rst,
  gcn_spmm_engine_if.slave bus
);
  localparam int NW    = LANES * W_ROWS;
  localparam int CNT_W = $clog2(NW + 1);
  localparam int AW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW    = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    ACCUM,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [DATA_W-1:0] wram [NW];
  logic [CNT_W-1:0]         wcnt;
  logic signed [DATA_W-1:0] acc  [LANES];
  logic signed [DATA_W-1:0] obuf [LANES];
  logic [ROW_W-1:0]         cur_row;
  logic [ROW_W-1:0]         buf_row;
  logic [2:0]               lane;
  logic                     done_pend;
  logic                     tail_pend;
  logic                     w_ok;
  logic                     err;
  logic                     done;
  logic                     rdy;
  logic                     take;
  logic                     col_bad;
  logic                     same_row;
  logic                     wr_en;
  logic [AW-1:0]            wr_idx;
  logic [DATA_W-1:0]        out_data;

  logic [AW-1:0]            widx   [LANES];
  logic signed [DATA_W-1:0] wsel   [LANES];
  logic signed [PW-1:0]     pfull  [LANES];
  logic signed [PW-1:0]     pshift [LANES];
  logic signed [DATA_W-1:0] prod   [LANES];
  logic signed [DATA_W-1:0] sum    [LANES];

`ifdef GCN_SAT_EN
  localparam logic signed [PW-1:0] PMAX =
    {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN =
    {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] DMAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DMIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] sfull [LANES];
  logic [LANES-1:0]       pclamp;
  logic [LANES-1:0]       sclamp;
  logic                   any_p;
  logic                   any_s;
  logic                   sat;

  assign any_p = |pclamp;
  assign any_s = |sclamp;
`endif

  assign col_bad  = 32'(bus.i_col) >= 32'(W_ROWS);
  assign same_row = (bus.i_row == cur_row);
  assign take     = bus.i_valid && rdy;

  // Per-lane product of the incoming element and the running-sum update
  always_comb begin
`ifdef GCN_SAT_EN
    pclamp = '0;
    sclamp = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      widx[l] = col_bad ? '0 :
        AW'(l * W_ROWS) + AW'(bus.i_col);
      wsel[l] = col_bad ? '0 : wram[widx[l]];
      pfull[l] = PW'($signed(bus.i_data)) * PW'(wsel[l]);
      pshift[l] = pfull[l] >>> FRAC;
      prod[l] = DATA_W'(pshift[l]);
`ifdef GCN_SAT_EN
      if (pshift[l] > PMAX) begin
        prod[l] = DMAX;
        pclamp[l] = 1'b1;
      end else if (pshift[l] < PMIN) begin
        prod[l] = DMIN;
        pclamp[l] = 1'b1;
      end
      sfull[l] = {acc[l][DATA_W-1], acc[l]}
               + {prod[l][DATA_W-1], prod[l]};
      sum[l] = sfull[l][DATA_W-1:0];
      if (sfull[l][DATA_W] != sfull[l][DATA_W-1]) begin
        sum[l] = sfull[l][DATA_W] ? DMIN : DMAX;
        sclamp[l] = 1'b1;
      end
`else
      sum[l] = acc[l] + prod[l];
`endif
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and element-side ready
  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_wload) begin
          state_nx = (NW == 1) ? IDLE : LOAD_W;
        end else begin
          rdy = w_ok;
          if (bus.i_valid && w_ok)
            state_nx = bus.i_last ? DRAIN : ACCUM;
        end
      end
      LOAD_W: begin
        if (bus.i_wload && wcnt == CNT_W'(NW - 1))
          state_nx = IDLE;
      end
      ACCUM: begin
        rdy = 1'b1;
        if (bus.i_valid && (!same_row || bus.i_last))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (bus.i_ready && lane == 3'(LANES - 1)) begin
          if (done_pend)      state_nx = IDLE;
          else if (tail_pend) state_nx = DRAIN;
          else                state_nx = ACCUM;
        end
      end
    endcase
  end

  assign wr_en  = bus.i_wload &&
                  (state == IDLE || state == LOAD_W);
  assign wr_idx = (state == IDLE) ? '0 : AW'(wcnt);

  // Weight RAM write port; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en) wram[wr_idx] <= bus.i_wdata;
  end

  // Accumulators, output buffer, counters and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      acc       <= '{default: '0};
      obuf      <= '{default: '0};
      cur_row   <= '0;
      buf_row   <= '0;
      lane      <= '0;
      done_pend <= 1'b0;
      tail_pend <= 1'b0;
      w_ok      <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
`ifdef GCN_SAT_EN
      sat       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_wload) begin
            wcnt <= (NW == 1) ? '0 : CNT_W'(1);
            w_ok <= (NW == 1);
            err  <= 1'b0;
          end else if (take) begin
            cur_row <= bus.i_row;
            acc     <= prod;
            err     <= err | col_bad;
`ifdef GCN_SAT_EN
            sat <= bus.i_last ? (sat | any_p) : any_p;
`endif
            if (bus.i_last) begin
              obuf      <= prod;
              buf_row   <= bus.i_row;
              done_pend <= 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (bus.i_wload) begin
            if (wcnt == CNT_W'(NW - 1)) begin
              wcnt <= '0;
              w_ok <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ACCUM: begin
          if (take) begin
            err <= err | col_bad |
                   (bus.i_row < cur_row);
            if (same_row) begin
`ifdef GCN_SAT_EN
              sat <= sat | any_p | any_s;
`endif
              if (bus.i_last) begin
                obuf      <= sum;
                buf_row   <= cur_row;
                done_pend <= 1'b1;
              end else begin
                acc <= sum;
              end
            end else begin
`ifdef GCN_SAT_EN
              sat <= sat | any_p;
`endif
              obuf      <= acc;
              buf_row   <= cur_row;
              acc       <= prod;
              cur_row   <= bus.i_row;
              tail_pend <= bus.i_last;
            end
          end
        end
        DRAIN: begin
          if (bus.i_ready) begin
            if (lane == 3'(LANES - 1)) begin
              lane <= '0;
              if (done_pend) begin
                done      <= 1'b1;
                done_pend <= 1'b0;
              end else if (tail_pend) begin
                obuf      <= acc;
                buf_row   <= cur_row;
                tail_pend <= 1'b0;
                done_pend <= 1'b1;
              end
            end else begin
              lane <= lane + 3'd1;
            end
          end
        end
      endcase
    end
  end

  // Lane mux for the result word
  always_comb begin
    out_data = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane == 3'(l)) out_data = obuf[l];
    end
  end

  assign bus.o_ready = rdy;
  assign bus.o_valid = (state == DRAIN);
  assign bus.o_row   = buf_row;
  assign bus.o_lane  = lane;
  assign bus.o_data  = out_data;
  assign bus.o_w_ok  = w_ok;
  assign bus.o_done  = done;
  assign bus.o_err   = err;
`ifdef GCN_SAT_EN
  assign bus.o_sat   = sat;
`endif

endmodule
